// File: rtl/cpu_axi_bridge_pkg.sv
// Shared types and constants for the CPU-to-AXI3 bridge.
// Optional round-robin arbitration: CPU_AXI_BRIDGE_RR_EN.
package cpu_axi_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR_REQ,
    WR_RESP
  } state_e;

  localparam logic [3:0] INST_ID = 4'd0;
  localparam logic [3:0] DATA_ID = 4'd1;

  localparam logic [1:0] BURST_INCR = 2'b01;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  function automatic logic [3:0] wstrb_of(
    input logic [1:0] size,
    input logic [1:0] off
  );
    case (size)
      SIZE_BYTE: wstrb_of = 4'b0001 << off;
      SIZE_HALF: wstrb_of = off[1] ? 4'b1100 : 4'b0011;
      default:   wstrb_of = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/cpu_axi_bridge_arb.sv
// Grant logic for the fetch and data request ports.
// CPU_AXI_BRIDGE_RR_EN selects round-robin; default is data-first.
module cpu_axi_bridge_arb
  import cpu_axi_bridge_pkg::*;
(
`ifdef CPU_AXI_BRIDGE_RR_EN
  input  logic clk,
  input  logic reset,
`endif
  input  logic idle,
  input  logic inst_req,
  input  logic data_req,
  output logic gnt_inst,
  output logic gnt_data
);

  logic data_wins;

`ifdef CPU_AXI_BRIDGE_RR_EN
  // last_data=1 hands the next tie to the fetch port
  logic last_data;

  assign data_wins = data_req & (~inst_req | ~last_data);

  always_ff @(posedge clk) begin
    if (reset)
      last_data <= 1'b0;
    else if (gnt_inst | gnt_data)
      last_data <= gnt_data;
  end
`else
  assign data_wins = data_req;
`endif

  assign gnt_data = idle & data_wins;
  assign gnt_inst = idle & inst_req & ~data_wins;

endmodule

// File: rtl/cpu_axi_bridge.sv
// SRAM-like fetch/data ports to a single-outstanding AXI3 master.
// Optional round-robin arbitration: CPU_AXI_BRIDGE_RR_EN.
module cpu_axi_bridge
  import cpu_axi_bridge_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  state_e      state, state_n;
  logic        gnt_inst, gnt_data;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        req_wr, req_data;
  logic        aw_done, w_done;

  // Ordering is guaranteed by the single outstanding transaction
  logic unused_ok;
  assign unused_ok = ^{rid, rresp, rlast, bid, bresp, req_wr};

  cpu_axi_bridge_arb u_arb (
`ifdef CPU_AXI_BRIDGE_RR_EN
    .clk      (clk),
    .reset    (reset),
`endif
    .idle     (state == IDLE),
    .inst_req (inst_req),
    .data_req (data_req),
    .gnt_inst (gnt_inst),
    .gnt_data (gnt_data)
  );

  assign inst_addr_ok = gnt_inst;
  assign data_addr_ok = gnt_data;

  always_comb begin
    state_n = state;
    arvalid = 1'b0;
    rready  = 1'b0;
    awvalid = 1'b0;
    wvalid  = 1'b0;
    bready  = 1'b0;
    unique case (state)
      IDLE: begin
        if (gnt_data)
          state_n = data_wr ? WR_REQ : RD_ADDR;
        else if (gnt_inst)
          state_n = RD_ADDR;
      end
      RD_ADDR: begin
        arvalid = 1'b1;
        if (arready) state_n = RD_DATA;
      end
      RD_DATA: begin
        rready = 1'b1;
        if (rvalid) state_n = IDLE;
      end
      WR_REQ: begin
        awvalid = ~aw_done;
        wvalid  = ~w_done;
        if ((aw_done | awready) & (w_done | wready))
          state_n = WR_RESP;
      end
      WR_RESP: begin
        bready = 1'b1;
        if (bvalid) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      req_addr     <= '0;
      req_wdata    <= '0;
      req_size     <= '0;
      req_wr       <= 1'b0;
      req_data     <= 1'b0;
      aw_done      <= 1'b0;
      w_done       <= 1'b0;
      inst_data_ok <= 1'b0;
      data_data_ok <= 1'b0;
      inst_rdata   <= '0;
      data_rdata   <= '0;
    end else begin
      state        <= state_n;
      inst_data_ok <= 1'b0;
      data_data_ok <= 1'b0;
      if (gnt_data) begin
        req_addr  <= data_addr;
        req_size  <= data_size;
        req_wdata <= data_wdata;
        req_wr    <= data_wr;
        req_data  <= 1'b1;
      end else if (gnt_inst) begin
        req_addr  <= inst_addr;
        req_size  <= inst_size;
        req_wdata <= '0;
        req_wr    <= 1'b0;
        req_data  <= 1'b0;
      end
      if (state == IDLE) begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end
      if (awvalid & awready) aw_done <= 1'b1;
      if (wvalid & wready)   w_done  <= 1'b1;
      if (rready & rvalid) begin
        if (req_data) begin
          data_rdata   <= rdata;
          data_data_ok <= 1'b1;
        end else begin
          inst_rdata   <= rdata;
          inst_data_ok <= 1'b1;
        end
      end
      if (bready & bvalid) data_data_ok <= 1'b1;
    end
  end

  assign arid    = req_data ? DATA_ID : INST_ID;
  assign araddr  = req_addr;
  assign arlen   = 8'd0;
  assign arsize  = {1'b0, req_size};
  assign arburst = BURST_INCR;
  assign arlock  = 2'b00;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;

  assign awid    = DATA_ID;
  assign awaddr  = req_addr;
  assign awlen   = 8'd0;
  assign awsize  = {1'b0, req_size};
  assign awburst = BURST_INCR;
  assign awlock  = 2'b00;
  assign awcache = 4'd0;
  assign awprot  = 3'd0;

  assign wid     = DATA_ID;
  assign wdata   = req_wdata;
  assign wstrb   = wstrb_of(req_size, req_addr[1:0]);
  assign wlast   = 1'b1;

endmodule

// File: tb/tb_cpu_axi_bridge.sv
// Randomized bench for cpu_axi_bridge with a transaction-level model.
// Honours CPU_AXI_BRIDGE_RR_EN for the expected arbitration order.
module tb_cpu_axi_bridge;

`ifdef CPU_AXI_BRIDGE_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  localparam logic [46:0] FIXED = {8'd0, 2'b01, 2'b00, 4'd0, 3'd0,
                                   8'd0, 2'b01, 2'b00, 4'd0, 3'd0,
                                   1'b1, 4'd1, 4'd1};

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic inst_req = 1'b0, data_req = 1'b0, data_wr = 1'b0;
  logic [1:0] inst_size = '0, data_size = '0;
  logic [31:0] inst_addr = '0, data_addr = '0, data_wdata = '0;
  logic inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic [3:0] arid, awid, wid, wstrb, arcache, awcache;
  logic [31:0] araddr, awaddr, wdata;
  logic [7:0] arlen, awlen;
  logic [2:0] arsize, awsize, arprot, awprot;
  logic [1:0] arburst, arlock, awburst, awlock;
  logic arvalid, rready, awvalid, wvalid, wlast, bready;
  logic arready = 1'b0, rvalid = 1'b0, rlast = 1'b1;
  logic awready = 1'b0, wready = 1'b0, bvalid = 1'b0;
  logic [3:0] rid = '0, bid = '0;
  logic [1:0] rresp = '0, bresp = '0;
  logic [31:0] rdata = '0;

  cpu_axi_bridge dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
    .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_rdata(data_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arlock(arlock), .arcache(arcache),
    .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awlock(awlock), .awcache(awcache),
    .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_bad = 0, cyc = 0;

  // transaction-level model
  bit busy, t_data, t_wr, ar_done, aw_done, w_done, r_pend, b_pend;
  logic [31:0] t_addr, t_wdata;
  logic [1:0] t_size;
  bit ok_inst, ok_data, rr_last_data, inst_acc, data_acc;
  logic [31:0] m_inst_rdata, m_data_rdata, r_val;
  int ph_cnt, aw_cnt, w_cnt;
  int ar_dly = 0, r_dly = 0, aw_dly = 0, w_dly = 0, b_dly = 0;
  int inst_pct = 0, data_pct = 0;
  bit d_pend, i_pend, fix_r;
  logic d_wr_p;
  logic [1:0] d_size_p;
  logic [31:0] d_addr_p, d_wdata_p, i_addr_p, fix_rval;
  int t_acc_inst, t_acc_data, t_ok_inst, t_ok_data, t_aw, t_w, t_b;
  int n_dok;
  logic [3:0] cap_arid, cap_wstrb;
  logic [2:0] cap_arsize, cap_awsize;
  bit glog[$];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %0h expected %0h",
               name, cyc, act, exp);
    end
  endtask

  function automatic logic pol(input int cnt, input int dly);
    if (dly < 0) return $urandom_range(0, 2) == 0;
    return cnt >= dly;
  endfunction

  function automatic logic [3:0] exp_strb(input logic [1:0] sz,
                                          input logic [31:0] a);
    int off;
    off = int'(a[1:0]);
    if (sz == 2'd0) return 4'(1 << off);
    if (sz == 2'd1) return 4'(3 << (a[1] ? 2 : 0));
    return 4'hF;
  endfunction

  task automatic model_clear();
    busy = 1'b0; ok_inst = 1'b0; ok_data = 1'b0;
    r_pend = 1'b0; b_pend = 1'b0; rr_last_data = 1'b0;
    inst_acc = 1'b0; data_acc = 1'b0;
    m_inst_rdata = '0; m_data_rdata = '0;
    d_pend = 1'b0; i_pend = 1'b0;
    glog.delete();
  endtask

  task automatic drive();
    if (!(inst_req && !inst_acc)) begin
      if (i_pend) begin
        inst_req = 1'b1; inst_addr = i_addr_p; inst_size = 2'd2;
        i_pend = 1'b0;
      end else if (inst_pct > 0 && $urandom_range(0, 99) < inst_pct) begin
        inst_req = 1'b1; inst_addr = $urandom;
        inst_size = 2'($urandom_range(0, 2));
      end else
        inst_req = 1'b0;
    end
    inst_acc = 1'b0;
    if (!(data_req && !data_acc)) begin
      if (d_pend) begin
        data_req = 1'b1; data_wr = d_wr_p; data_addr = d_addr_p;
        data_size = d_size_p; data_wdata = d_wdata_p; d_pend = 1'b0;
      end else if (data_pct > 0 && $urandom_range(0, 99) < data_pct) begin
        data_req = 1'b1; data_wr = 1'($urandom_range(0, 1));
        data_addr = $urandom; data_wdata = $urandom;
        data_size = 2'($urandom_range(0, 2));
      end else
        data_req = 1'b0;
    end
    data_acc = 1'b0;
    arready = busy && !t_wr && !ar_done && pol(ph_cnt, ar_dly);
    rvalid  = r_pend && pol(ph_cnt, r_dly);
    rdata   = rvalid ? r_val : $urandom;
    rid = 4'($urandom); rresp = 2'($urandom);
    awready = busy && t_wr && !aw_done && pol(aw_cnt, aw_dly);
    wready  = busy && t_wr && !w_done && pol(w_cnt, w_dly);
    bvalid  = b_pend && pol(ph_cnt, b_dly);
    bid = 4'($urandom); bresp = 2'($urandom);
  endtask

  task automatic sample();
    bit ei, ed, a0, w0;
    #1;
    chk("inst_data_ok", 64'(inst_data_ok), 64'(ok_inst));
    chk("data_data_ok", 64'(data_data_ok), 64'(ok_data));
    chk("inst_rdata", 64'(inst_rdata), 64'(m_inst_rdata));
    chk("data_rdata", 64'(data_rdata), 64'(m_data_rdata));
    n_dok += int'(inst_data_ok) + int'(data_data_ok);
    if (ok_inst) t_ok_inst = cyc;
    if (ok_data) t_ok_data = cyc;
    if (ok_inst || ok_data) busy = 1'b0;
    ok_inst = 1'b0; ok_data = 1'b0;
    if (!busy) begin
      chk("idle_axi", 64'({arvalid, rready, awvalid, wvalid, bready}), 64'(0));
    end else begin
      chk("fixed_fields", 64'({arlen, arburst, arlock, arcache, arprot,
                               awlen, awburst, awlock, awcache, awprot,
                               wlast, awid, wid}), 64'(FIXED));
      if (!t_wr && !ar_done) begin
        chk("ar_phase", 64'({arvalid, rready, awvalid, wvalid, bready}),
            64'(5'b10000));
        chk("araddr", 64'(araddr), 64'(t_addr));
        chk("arid", 64'(arid), t_data ? 64'(1) : 64'(0));
        chk("arsize", 64'(arsize), 64'({1'b0, t_size}));
        if (arready) begin
          ar_done = 1'b1; r_pend = 1'b1; ph_cnt = 0;
          r_val = fix_r ? fix_rval : $urandom;
          cap_arid = arid; cap_arsize = arsize;
        end else ph_cnt++;
      end else if (!t_wr) begin
        chk("r_phase", 64'({arvalid, rready, awvalid, wvalid, bready}),
            64'(5'b01000));
        if (rvalid) begin
          r_pend = 1'b0;
          if (t_data) begin ok_data = 1'b1; m_data_rdata = r_val; end
          else begin ok_inst = 1'b1; m_inst_rdata = r_val; end
        end else ph_cnt++;
      end else if (!(aw_done && w_done)) begin
        chk("w_phase", 64'({arvalid, rready, awvalid, wvalid, bready}),
            64'({2'b00, !aw_done, !w_done, 1'b0}));
        chk("awaddr", 64'(awaddr), 64'(t_addr));
        chk("awsize", 64'(awsize), 64'({1'b0, t_size}));
        chk("wdata", 64'(wdata), 64'(t_wdata));
        chk("wstrb", 64'(wstrb), 64'(exp_strb(t_size, t_addr)));
        a0 = aw_done; w0 = w_done;
        if (!a0) begin
          if (awready) begin
            aw_done = 1'b1; t_aw = cyc; cap_awsize = awsize;
          end else aw_cnt++;
        end
        if (!w0) begin
          if (wready) begin
            w_done = 1'b1; t_w = cyc; cap_wstrb = wstrb;
          end else w_cnt++;
        end
        if (aw_done && w_done) begin b_pend = 1'b1; ph_cnt = 0; end
      end else begin
        chk("b_phase", 64'({arvalid, rready, awvalid, wvalid, bready}),
            64'(5'b00001));
        if (bvalid) begin
          b_pend = 1'b0; ok_data = 1'b1; t_b = cyc;
        end else ph_cnt++;
      end
    end
    ei = 1'b0; ed = 1'b0;
    if (!busy) begin
      if (data_req && inst_req) ed = RR ? !rr_last_data : 1'b1;
      else ed = data_req;
      ei = inst_req && !ed;
    end
    chk("inst_addr_ok", 64'(inst_addr_ok), 64'(ei));
    chk("data_addr_ok", 64'(data_addr_ok), 64'(ed));
    if (ei || ed) begin
      busy = 1'b1; t_data = ed; t_wr = ed && data_wr;
      t_addr = ed ? data_addr : inst_addr;
      t_size = ed ? data_size : inst_size;
      t_wdata = data_wdata;
      ar_done = 1'b0; aw_done = 1'b0; w_done = 1'b0;
      ph_cnt = 0; aw_cnt = 0; w_cnt = 0;
      rr_last_data = ed;
      glog.push_back(ed);
      if (ed) begin data_acc = 1'b1; t_acc_data = cyc; end
      else begin inst_acc = 1'b1; t_acc_inst = cyc; end
    end
    cyc++;
  endtask

  task automatic step();
    @(negedge clk);
    drive();
    sample();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    inst_req = 1'b0; data_req = 1'b0;
    arready = 1'b0; rvalid = 1'b0; awready = 1'b0;
    wready = 1'b0; bvalid = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_ctrl", 64'({arvalid, rready, awvalid, wvalid, bready,
                         inst_data_ok, data_data_ok,
                         inst_addr_ok, data_addr_ok}), 64'(0));
    chk("rst_inst_rdata", 64'(inst_rdata), 64'(0));
    chk("rst_data_rdata", 64'(data_rdata), 64'(0));
    chk("rst_req_regs", 64'({araddr, wdata}), 64'(0));
    reset = 1'b0;
    model_clear();
  endtask

  task automatic drain();
    inst_pct = 0; data_pct = 0;
    for (int i = 0; i < 300; i++) begin
      if (!busy && !inst_req && !data_req && !i_pend && !d_pend) break;
      step();
    end
    chk("drain_timeout", 64'({busy, inst_req, data_req}), 64'(0));
  endtask

  task automatic set_dly(input int d);
    ar_dly = d; r_dly = d; aw_dly = d; w_dly = d; b_dly = d;
  endtask

  task automatic data_op(input logic wr, input logic [31:0] a,
                         input logic [1:0] sz, input logic [31:0] wd);
    d_pend = 1'b1; d_wr_p = wr; d_addr_p = a;
    d_size_p = sz; d_wdata_p = wd;
  endtask

  initial begin
    int n0;
    model_clear();
    do_reset();
    set_dly(0);

    // zero-wait word read on the data port
    fix_r = 1'b1; fix_rval = 32'hDEADBEEF;
    t_ok_data = -1;
    data_op(1'b0, 32'h1FC0_0004, 2'd2, 32'd0);
    for (int i = 0; i < 50 && t_ok_data < 0; i++) step();
    chk("rd_latency", 64'(t_ok_data - t_acc_data), 64'(3));
    chk("rd_rdata", 64'(data_rdata), 64'(32'hDEADBEEF));
    chk("rd_arid", 64'(cap_arid), 64'(1));
    chk("rd_arsize", 64'(cap_arsize), 64'(3'b010));
    drain();

    // byte write to offset 3
    t_ok_data = -1;
    data_op(1'b1, 32'h0000_0103, 2'd0, 32'hAA00_0000);
    for (int i = 0; i < 50 && t_ok_data < 0; i++) step();
    chk("bw_wstrb", 64'(cap_wstrb), 64'(4'b1000));
    chk("bw_awsize", 64'(cap_awsize), 64'(0));
    chk("bw_ok_after_b", 64'(t_ok_data - t_b), 64'(1));
    chk("bw_latency", 64'(t_ok_data - t_acc_data), 64'(3));
    drain();

    // awready two cycles ahead of wready
    aw_dly = 0; w_dly = 2;
    n0 = n_dok; t_ok_data = -1;
    data_op(1'b1, 32'h0000_0042, 2'd1, 32'h1234_5678);
    for (int i = 0; i < 50 && t_ok_data < 0; i++) step();
    chk("split_aw_w_gap", 64'(t_w - t_aw), 64'(2));
    drain();
    for (int i = 0; i < 4; i++) step();
    chk("split_one_ok", 64'(n_dok - n0), 64'(1));
    set_dly(0);

    // both ports requesting continuously
    do_reset();
    inst_pct = 100; data_pct = 100; fix_r = 1'b0;
    for (int i = 0; i < 100 && glog.size() < 3; i++) step();
    chk("arb_count", 64'(glog.size() >= 3), 64'(1));
    if (glog.size() >= 3)
      chk("arb_order", 64'({glog[0], glog[1], glog[2]}),
          RR ? 64'(3'b101) : 64'(3'b111));
    drain();

    // slow arready with a second request waiting
    ar_dly = 5;
    t_acc_data = -1;
    i_pend = 1'b1; i_addr_p = 32'hBFC0_0000;
    step();
    data_op(1'b0, 32'h0000_0200, 2'd2, 32'd0);
    for (int i = 0; i < 50 && t_acc_data < 0; i++) step();
    chk("busy_wait_gap", 64'(t_acc_data - t_acc_inst), 64'(8));
    drain();
    set_dly(0);

    // reset while waiting for read data
    r_dly = 1000;
    data_op(1'b0, 32'h0000_0300, 2'd2, 32'd0);
    for (int i = 0; i < 50 && !(busy && ar_done); i++) step();
    chk("in_rd_data", 64'({busy, ar_done}), 64'(2'b11));
    step();
    do_reset();
    r_dly = 0;
    for (int i = 0; i < 5; i++) step();

    // randomized traffic and slave delays
    do_reset();
    set_dly(-1);
    inst_pct = 30; data_pct = 30;
    for (int i = 0; i < 3000; i++) step();
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
